hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
//  Parametrised forwarding/hazard unit for the in-order pipeline.
//  - Forwarding: selects, per EX read port, the youngest in-flight producer among NUM_FWD_SRC stages.
//  - Load-use: detects producers whose data is not yet available.
//  - Long-latency ops (mul/div): per-register countdown scoreboard.
//  - Output: one EX stall request, plus a saturating stall-cycle counter.
//  Sits beside ID/EX; drives the ALU operand muxes and the pipeline stall/bubble logic.
// PARAMETERS
//  NUM_FWD_SRC    2    forwarding sources; index 0 = youngest (EXMEM), 1 = MEMWB, ...
//  NUM_READ_PORTS 2    EX source operands checked (rs1, rs2, ...)
//  REG_ADDR_W     5    architectural register index width
//  MAX_LAT        8    longest long-latency op, in cycles
//  SEL_W          $clog2(NUM_FWD_SRC+1)   forward-select width (derived, localparam)
//  CNT_W          $clog2(MAX_LAT+1)       scoreboard counter width (derived, localparam)
// PORTS
//  clk                 in   1                       pipeline clock
//  reset               in   1                       synchronous, active-low reset
//  in_IDEX_valid       in   1                       ID/EX holds a real instruction
//  in_IDEX_rs          in   NUM_READ_PORTS*REG_ADDR_W   source regs; port p at [p*REG_ADDR_W +: REG_ADDR_W]
//  in_fwd_rd           in   NUM_FWD_SRC*REG_ADDR_W  destination reg of each forwarding stage
//  in_fwd_write_enable in   NUM_FWD_SRC             stage s writes in_fwd_rd[s]
//  in_fwd_data_ready   in   NUM_FWD_SRC             stage s result is available (0 = load in flight)
//  in_issue_valid      in   1                       long-latency op leaves EX this cycle
//  in_issue_rd         in   REG_ADDR_W              its destination register
//  in_issue_latency    in   CNT_W                   cycles until its result is forwardable
//  in_flush            in   1                       ID/EX contents squashed this cycle
//  out_fwd_sel         out  NUM_READ_PORTS*SEL_W    0 = regfile, s+1 = forward from stage s
//  out_stall           out  1                       hold IF/ID, bubble into EX
//  out_stall_count     out  32                      cycles with out_stall=1, saturating
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//  - All scoreboard counters and out_stall_count clear to 0.
//  - Combinational outputs then read out_fwd_sel=0 and out_stall=0, given in_IDEX_valid=0.
//  Forward select (combinational, zero latency), per port p:
//  - Register x0 never matches.
//  - Among stages s with in_fwd_write_enable[s] && in_fwd_rd[s]==rs[p], the lowest s wins: sel=s+1.
//  - If no stage matches, sel=0.
//  - out_fwd_sel is computed regardless of in_IDEX_valid.
//  Stall (combinational), asserted iff in_IDEX_valid && !in_flush && any port p has either:
//  - (a) winning stage s with in_fwd_data_ready[s]==0 (load-use), or
//  - (b) scoreboard counter[rs[p]] != 0.
//  - The unit asserts no stall for rs==x0.
//  Scoreboard, one CNT_W counter per register 1..2^REG_ADDR_W-1 (x0 is not stored), updated each posedge:
//  - Every nonzero counter decrements by 1.
//  - On in_issue_valid with in_issue_rd!=0:
//    - the counter loads L=min(in_issue_latency, MAX_LAT);
//    - issue overrides the decrement on the same register;
//    - WAW: if the counter is already nonzero, it loads max(current-1, L).
//  - in_issue_latency==0 or in_issue_rd==0: no scoreboard change.
//  - A counter at 1 reads as pending this cycle, free the next; the producer must appear on a forwarding stage by then.
//  in_flush:
//  - Suppresses the stall the same cycle.
//  - Does NOT clear the scoreboard; issued ops are older than the flushed instruction.
//  out_stall_count:
//  - +1 on each posedge where out_stall==1.
//  - Holds at 32'hFFFF_FFFF once reached.
//  Reset mid-operation: all pending counters drop to 0 on the same edge; there is no drain.
// STRUCTURE
//  - Shared package hazard_pkg: fwd_sel_t encoding constants FWD_REGFILE=0 and FWD_STAGE_BASE=1, plus the default REG_ADDR_W.
//  - One sub-module, reg_scoreboard: counter array, issue/decrement/WAW logic, and a pending-lookup function/port per read port.
//  - Priority select and stall OR-reduction: generate loops in the top module.
// TESTING
//  1. Reset low 2 cycles -> all out_fwd_sel=0, out_stall=0, out_stall_count=0.
//  2. Stage0 rd=5 we, stage1 rd=5 we, rs1=5, rs2=0 -> sel[0]=1 (youngest wins), sel[1]=0, no stall.
//  3. Load-use: stage0 rd=7 we, data_ready=0, rs2=7, valid=1 -> stall=1.
//     Next cycle data_ready=1 -> stall=0, sel[1]=1; count==1.
//  4. Issue rd=9 latency=3, next-cycle rs1=9 -> stall for exactly 3 cycles, then released.
//     Issue with latency=12 -> saturates to 8 stall cycles.
//  5. Issue rd=4 L=6; two cycles later issue rd=4 L=2 -> counter keeps 3 (WAW max).
//     Issue with rd=0 -> no stall ever.
//  6. Pending rd=3, rs1=3 with in_flush=1 -> stall=0; counter still decrements.
//     Assert reset mid-count -> rs1=3 no longer stalls.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the forwarding/hazard unit: forward-select encoding
// and default register-index width.
package hazard_pkg;

  localparam int unsigned DEFAULT_REG_ADDR_W = 5;

  // Forward-select encoding: 0 reads the regfile, stage s is FWD_STAGE_BASE + s.
  typedef enum int unsigned {
    FWD_REGFILE    = 0,
    FWD_STAGE_BASE = 1
  } fwd_sel_t;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Bus between the ID/EX pipeline logic and the forwarding/hazard unit.
interface hazard_forward_unit_if
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_FWD_SRC    = 2,
  parameter int unsigned NUM_READ_PORTS = 2,
  parameter int unsigned REG_ADDR_W     = DEFAULT_REG_ADDR_W,
  parameter int unsigned MAX_LAT        = 8
);

  localparam int unsigned SEL_W = $clog2(NUM_FWD_SRC + 1);
  localparam int unsigned CNT_W = $clog2(MAX_LAT + 1);

  logic                                 in_IDEX_valid;
  logic [NUM_READ_PORTS*REG_ADDR_W-1:0] in_IDEX_rs;
  logic [NUM_FWD_SRC*REG_ADDR_W-1:0]    in_fwd_rd;
  logic [NUM_FWD_SRC-1:0]               in_fwd_write_enable;
  logic [NUM_FWD_SRC-1:0]               in_fwd_data_ready;
  logic                                 in_issue_valid;
  logic [REG_ADDR_W-1:0]                in_issue_rd;
  logic [CNT_W-1:0]                     in_issue_latency;
  logic                                 in_flush;
  logic [NUM_READ_PORTS*SEL_W-1:0]      out_fwd_sel;
  logic                                 out_stall;
  logic [31:0]                          out_stall_count;

  modport master (
    output in_IDEX_valid, in_IDEX_rs, in_fwd_rd, in_fwd_write_enable,
           in_fwd_data_ready, in_issue_valid, in_issue_rd, in_issue_latency,
           in_flush,
    input  out_fwd_sel, out_stall, out_stall_count
  );

  modport slave (
    input  in_IDEX_valid, in_IDEX_rs, in_fwd_rd, in_fwd_write_enable,
           in_fwd_data_ready, in_issue_valid, in_issue_rd, in_issue_latency,
           in_flush,
    output out_fwd_sel, out_stall, out_stall_count
  );

endinterface

// File: rtl/hazard_forward_unit_reg_scoreboard.sv
// Per-register countdown scoreboard for long-latency ops; x0 has no entry.
// Reports, per read port, whether the addressed register is still pending.
module reg_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_READ_PORTS = 2,
  parameter int unsigned REG_ADDR_W     = DEFAULT_REG_ADDR_W,
  parameter int unsigned MAX_LAT        = 8,
  localparam int unsigned CNT_W         = $clog2(MAX_LAT + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 issue_valid,
  input  logic [REG_ADDR_W-1:0]                issue_rd,
  input  logic [CNT_W-1:0]                     issue_latency,
  input  logic [NUM_READ_PORTS*REG_ADDR_W-1:0] rd_addr,
  output logic [NUM_READ_PORTS-1:0]            pending
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;

  logic [CNT_W-1:0] cnt_q [1:NUM_REGS-1];
  logic [CNT_W-1:0] cnt_d [1:NUM_REGS-1];
  logic [CNT_W-1:0] lat_clamped;

  always_comb begin
    lat_clamped = (issue_latency > CNT_W'(MAX_LAT)) ? CNT_W'(MAX_LAT) : issue_latency;
  end

  // Decrement everything; an issue loads max(decremented, L), covering WAW.
  always_comb begin
    for (int r = 1; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : '0;
      if (issue_valid && (issue_rd == REG_ADDR_W'(r)) && (issue_latency != '0) &&
          (lat_clamped > cnt_d[r])) begin
        cnt_d[r] = lat_clamped;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 1; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    pending = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if ((rd_addr[p*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(r)) && (cnt_q[r] != '0)) begin
          pending[p] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding/hazard unit beside ID/EX: per-port forward select, load-use and
// long-latency stall detection, and a saturating stall-cycle counter.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_FWD_SRC    = 2,
  parameter int unsigned NUM_READ_PORTS = 2,
  parameter int unsigned REG_ADDR_W     = DEFAULT_REG_ADDR_W,
  parameter int unsigned MAX_LAT        = 8
) (
  input logic                  clk,
  input logic                  reset,
  hazard_forward_unit_if.slave bus
);

  localparam int unsigned SEL_W = $clog2(NUM_FWD_SRC + 1);

  logic [NUM_READ_PORTS-1:0] sb_pending;
  logic [NUM_READ_PORTS-1:0] load_use;
  logic [31:0]               stall_count_q;

  reg_scoreboard #(
    .NUM_READ_PORTS(NUM_READ_PORTS),
    .REG_ADDR_W    (REG_ADDR_W),
    .MAX_LAT       (MAX_LAT)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (bus.in_issue_valid),
    .issue_rd     (bus.in_issue_rd),
    .issue_latency(bus.in_issue_latency),
    .rd_addr      (bus.in_IDEX_rs),
    .pending      (sb_pending)
  );

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
    logic [REG_ADDR_W-1:0] rs;
    logic [SEL_W-1:0]      sel;
    logic                  hit_ready;

    assign rs = bus.in_IDEX_rs[p*REG_ADDR_W +: REG_ADDR_W];

    // Scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
      sel       = SEL_W'(FWD_REGFILE);
      hit_ready = 1'b1;
      for (int s = NUM_FWD_SRC - 1; s >= 0; s--) begin
        if ((rs != '0) && bus.in_fwd_write_enable[s] &&
            (bus.in_fwd_rd[s*REG_ADDR_W +: REG_ADDR_W] == rs)) begin
          sel       = SEL_W'(s + int'(FWD_STAGE_BASE));
          hit_ready = bus.in_fwd_data_ready[s];
        end
      end
    end

    assign bus.out_fwd_sel[p*SEL_W +: SEL_W] = sel;
    assign load_use[p] = !hit_ready;
  end

  assign bus.out_stall = bus.in_IDEX_valid && !bus.in_flush && (|(load_use | sb_pending));

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_count_q <= '0;
    end else if (bus.out_stall && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign bus.out_stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: forwarding priority, load-use,
// scoreboard latency/saturation/WAW, flush and mid-count reset.
module tb_hazard_forward_unit;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;
  int   n;

  always #5 clk = ~clk;

  hazard_forward_unit_if #(.NUM_FWD_SRC(2), .NUM_READ_PORTS(2), .REG_ADDR_W(5), .MAX_LAT(8)) bus ();

  hazard_forward_unit #(.NUM_FWD_SRC(2), .NUM_READ_PORTS(2), .REG_ADDR_W(5), .MAX_LAT(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Count stall cycles over a fixed window, stepping the clock each cycle.
  task automatic count_stalls(input int cycles, output int stalls);
    stalls = 0;
    for (int i = 0; i < cycles; i++) begin
      #1;
      if (bus.out_stall) stalls++;
      step();
    end
  endtask

  function automatic logic [1:0] sel_of(input int p);
    logic [3:0] v;
    v = bus.out_fwd_sel;
    return v[p*2 +: 2];
  endfunction

  initial begin
    reset                   = 1'b0;
    bus.in_IDEX_valid       = 1'b0;
    bus.in_IDEX_rs          = '0;
    bus.in_fwd_rd           = '0;
    bus.in_fwd_write_enable = '0;
    bus.in_fwd_data_ready   = '0;
    bus.in_issue_valid      = 1'b0;
    bus.in_issue_rd         = '0;
    bus.in_issue_latency    = '0;
    bus.in_flush            = 1'b0;

    // Reset state
    step(); step();
    check("rst_sel0", 32'(sel_of(0)), 0);
    check("rst_sel1", 32'(sel_of(1)), 0);
    check("rst_stall", 32'(bus.out_stall), 0);
    check("rst_count", bus.out_stall_count, 0);
    reset = 1'b1;
    step();

    // Youngest producer wins; rs2=x0 reads regfile
    bus.in_fwd_rd           = {5'd5, 5'd5};
    bus.in_fwd_write_enable = 2'b11;
    bus.in_fwd_data_ready   = 2'b11;
    bus.in_IDEX_rs          = {5'd0, 5'd5};
    bus.in_IDEX_valid       = 1'b1;
    #1;
    check("fwd_young_sel0", 32'(sel_of(0)), 1);
    check("fwd_young_sel1", 32'(sel_of(1)), 0);
    check("fwd_young_stall", 32'(bus.out_stall), 0);
    bus.in_fwd_write_enable = 2'b10;
    #1;
    check("fwd_stage1_sel0", 32'(sel_of(0)), 2);
    bus.in_fwd_write_enable = 2'b00;
    #1;
    check("fwd_none_sel0", 32'(sel_of(0)), 0);
    bus.in_fwd_rd           = {5'd0, 5'd0};
    bus.in_fwd_write_enable = 2'b11;
    bus.in_IDEX_rs          = {5'd0, 5'd0};
    #1;
    check("fwd_x0_sel0", 32'(sel_of(0)), 0);
    check("fwd_x0_sel1", 32'(sel_of(1)), 0);

    // Load-use on rs2
    bus.in_fwd_rd           = {5'd0, 5'd7};
    bus.in_fwd_write_enable = 2'b01;
    bus.in_fwd_data_ready   = 2'b00;
    bus.in_IDEX_rs          = {5'd7, 5'd0};
    bus.in_IDEX_valid       = 1'b0;
    #1;
    check("lu_invalid_stall", 32'(bus.out_stall), 0);
    bus.in_IDEX_valid = 1'b1;
    #1;
    check("lu_stall", 32'(bus.out_stall), 1);
    check("lu_sel1", 32'(sel_of(1)), 1);
    step();
    bus.in_fwd_data_ready = 2'b01;
    #1;
    check("lu_ready_stall", 32'(bus.out_stall), 0);
    check("lu_ready_sel1", 32'(sel_of(1)), 1);
    check("lu_count", bus.out_stall_count, 1);
    // Ready youngest shadows an older in-flight load of the same register
    bus.in_fwd_rd           = {5'd7, 5'd7};
    bus.in_fwd_write_enable = 2'b11;
    bus.in_fwd_data_ready   = 2'b01;
    #1;
    check("lu_shadow_stall", 32'(bus.out_stall), 0);
    bus.in_fwd_write_enable = 2'b00;

    // Long-latency issue rd=9 L=3
    bus.in_IDEX_valid    = 1'b0;
    bus.in_issue_valid   = 1'b1;
    bus.in_issue_rd      = 5'd9;
    bus.in_issue_latency = 4'd3;
    step();
    bus.in_issue_valid = 1'b0;
    bus.in_IDEX_valid  = 1'b1;
    bus.in_IDEX_rs     = {5'd0, 5'd9};
    count_stalls(12, n);
    check("lat3_stalls", 32'(n), 3);
    check("lat3_count", bus.out_stall_count, 4);

    // Latency 12 clamps to MAX_LAT
    bus.in_IDEX_valid    = 1'b0;
    bus.in_issue_valid   = 1'b1;
    bus.in_issue_latency = 4'd12;
    step();
    bus.in_issue_valid = 1'b0;
    bus.in_IDEX_valid  = 1'b1;
    count_stalls(16, n);
    check("lat12_stalls", 32'(n), 8);
    check("lat12_count", bus.out_stall_count, 12);

    // WAW: rd=4 L=6 -> 6,5,4; reissue L=2 keeps max(3,2)=3
    bus.in_IDEX_valid    = 1'b0;
    bus.in_issue_valid   = 1'b1;
    bus.in_issue_rd      = 5'd4;
    bus.in_issue_latency = 4'd6;
    step();
    bus.in_issue_valid = 1'b0;
    step(); step();
    bus.in_issue_valid   = 1'b1;
    bus.in_issue_latency = 4'd2;
    step();
    bus.in_issue_valid = 1'b0;
    bus.in_IDEX_valid  = 1'b1;
    bus.in_IDEX_rs     = {5'd0, 5'd4};
    count_stalls(10, n);
    check("waw_stalls", 32'(n), 3);

    // Issue to x0 and zero-latency issue never stall
    bus.in_IDEX_valid    = 1'b0;
    bus.in_issue_valid   = 1'b1;
    bus.in_issue_rd      = 5'd0;
    bus.in_issue_latency = 4'd5;
    step();
    bus.in_issue_rd      = 5'd6;
    bus.in_issue_latency = 4'd0;
    step();
    bus.in_issue_valid = 1'b0;
    bus.in_IDEX_valid  = 1'b1;
    bus.in_IDEX_rs     = {5'd6, 5'd0};
    count_stalls(8, n);
    check("x0_lat0_stalls", 32'(n), 0);
    check("x0_lat0_count", bus.out_stall_count, 15);

    // Flush suppresses stall but scoreboard keeps counting: rd=3 L=4
    bus.in_IDEX_valid    = 1'b0;
    bus.in_issue_valid   = 1'b1;
    bus.in_issue_rd      = 5'd3;
    bus.in_issue_latency = 4'd4;
    step();
    bus.in_issue_valid = 1'b0;
    bus.in_IDEX_valid  = 1'b1;
    bus.in_IDEX_rs     = {5'd0, 5'd3};
    bus.in_flush       = 1'b1;
    #1;
    check("flush_stall", 32'(bus.out_stall), 0);
    step();
    bus.in_flush = 1'b0;
    count_stalls(10, n);
    check("flush_remaining_stalls", 32'(n), 3);
    check("flush_count", bus.out_stall_count, 18);

    // Reset mid-count drops pending counters
    bus.in_IDEX_valid    = 1'b0;
    bus.in_issue_valid   = 1'b1;
    bus.in_issue_latency = 4'd8;
    step();
    bus.in_issue_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    reset             = 1'b1;
    bus.in_IDEX_valid = 1'b1;
    #1;
    check("midrst_stall", 32'(bus.out_stall), 0);
    check("midrst_count", bus.out_stall_count, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
